// File: rtl/mem_arbiter_if.sv
// Bus bundle between the instruction/data requesters, the arbiter and the shared RAM port.
interface mem_arbiter_if #(
  parameter int unsigned WORD_W = 32
);
  logic              iREN;
  logic [WORD_W-1:0] iaddr;
  logic              iwait;
  logic [WORD_W-1:0] iload;

  logic              dREN;
  logic              dWEN;
  logic [WORD_W-1:0] daddr;
  logic [WORD_W-1:0] dstore;
  logic              dwait;
  logic [WORD_W-1:0] dload;

  logic              ramREN;
  logic              ramWEN;
  logic [WORD_W-1:0] ramaddr;
  logic [WORD_W-1:0] ramstore;
  logic [WORD_W-1:0] ramload;
  logic              ramready;

  // Arbiter side.
  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramready,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  // Requester / RAM side.
  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramready,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (instruction/data) arbiter for a single shared RAM port.
// Data wins ties unless the instruction side has waited through STARVE_MAX data grants.
module mem_arbiter #(
  parameter int unsigned WORD_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic         CLK,
  input  logic         RST,
  mem_arbiter_if.slave bus
);

  localparam int unsigned SCNT_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  typedef enum logic [2:0] {
    IDLE,
    D_ACC,
    I_ACC,
    D_RESP,
    I_RESP
  } state_t;

  state_t            state, state_n;
  logic [SCNT_W-1:0] scount, scount_n;
  logic [WORD_W-1:0] addr_q, addr_n;
  logic [WORD_W-1:0] store_q, store_n;
  logic              wr_q, wr_n;
  logic              ren_q, ren_n;
  logic              wen_q, wen_n;
  logic              iwait_q, dwait_q;
  logic [WORD_W-1:0] iload_q, dload_q;
  logic              cap_d, cap_i;
  logic              d_req, starve, acc_n;

  // Arbitration, access sequencing and next-cycle RAM strobes.
  always_comb begin
    state_n  = state;
    scount_n = scount;
    addr_n   = addr_q;
    store_n  = store_q;
    wr_n     = wr_q;
    cap_d    = 1'b0;
    cap_i    = 1'b0;
    d_req    = bus.dREN | bus.dWEN;
    starve   = bus.iREN && (scount == SCNT_W'(STARVE_MAX));

    unique case (state)
      IDLE: begin
        if (d_req && !starve) begin
          state_n = D_ACC;
          addr_n  = bus.daddr;
          store_n = bus.dstore;
          wr_n    = bus.dWEN;
          if (bus.iREN) scount_n = scount + SCNT_W'(1);
        end else if (bus.iREN) begin
          state_n  = I_ACC;
          addr_n   = bus.iaddr;
          store_n  = '0;
          wr_n     = 1'b0;
          scount_n = '0;
        end
      end
      D_ACC: begin
        if (bus.ramready) begin
          state_n = D_RESP;
          cap_d   = 1'b1;
        end
      end
      I_ACC: begin
        if (bus.ramready) begin
          state_n = I_RESP;
          cap_i   = 1'b1;
        end
      end
      D_RESP, I_RESP: state_n = IDLE;
      default:        state_n = IDLE;
    endcase

    acc_n = (state_n == D_ACC) || (state_n == I_ACC);
    ren_n = acc_n && !wr_n;
    wen_n = acc_n && wr_n;
  end

  // State, latched request and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      scount  <= '0;
      addr_q  <= '0;
      store_q <= '0;
      wr_q    <= 1'b0;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
      iwait_q <= 1'b1;
      dwait_q <= 1'b1;
      iload_q <= '0;
      dload_q <= '0;
    end else begin
      state   <= state_n;
      scount  <= scount_n;
      addr_q  <= addr_n;
      store_q <= store_n;
      wr_q    <= wr_n;
      ren_q   <= ren_n;
      wen_q   <= wen_n;
      iwait_q <= (state_n != I_RESP);
      dwait_q <= (state_n != D_RESP);
      if (cap_i) iload_q <= bus.ramload;
      if (cap_d) dload_q <= bus.ramload;
    end
  end

  assign bus.ramREN   = ren_q;
  assign bus.ramWEN   = wen_q;
  assign bus.ramaddr  = addr_q;
  assign bus.ramstore = store_q;
  assign bus.iwait    = iwait_q;
  assign bus.iload    = iload_q;
  assign bus.dwait    = dwait_q;
  assign bus.dload    = dload_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, starvation/back-to-back sequences, random vs. model.
module tb_mem_arbiter;
  localparam int unsigned W    = 32;
  localparam int unsigned SMAX = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if #(.WORD_W(W)) bus ();

  mem_arbiter #(.WORD_W(W), .STARVE_MAX(SMAX)) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic drv(input bit r, input bit ir, input bit dr, input bit dw,
                     input logic [W-1:0] ia, input logic [W-1:0] da, input logic [W-1:0] ds,
                     input bit rr, input logic [W-1:0] rl);
    rst          = r;
    bus.iREN     = ir;
    bus.dREN     = dr;
    bus.dWEN     = dw;
    bus.iaddr    = ia;
    bus.daddr    = da;
    bus.dstore   = ds;
    bus.ramready = rr;
    bus.ramload  = rl;
  endtask

  // One row: inputs applied before an edge, outputs expected after it.
  typedef struct {
    bit rst, ir, dr, dw;
    logic [W-1:0] ia, da, ds;
    bit rr;
    logic [W-1:0] rl;
    bit e_iw, e_dw, e_ren, e_wen;
    bit c_addr;  logic [W-1:0] e_addr;
    bit c_store; logic [W-1:0] e_store;
    bit c_il;    logic [W-1:0] e_il;
    bit c_dl;    logic [W-1:0] e_dl;
  } vec_t;

  localparam int NV = 20;
  vec_t vt [NV];

  // Reference model: who owns the RAM and in which phase (0 idle, 1 access, 2 response).
  int           m_stage, m_owner, m_cnt;
  bit           m_wr, m_dl_ok;
  logic [W-1:0] m_addr, m_store, m_il, m_dl;

  task automatic model_step(input bit r, input bit ir, input bit dr, input bit dw,
                            input logic [W-1:0] ia, input logic [W-1:0] da,
                            input logic [W-1:0] ds, input bit rr, input logic [W-1:0] rl);
    if (r) begin
      m_stage = 0; m_owner = 0; m_cnt = 0; m_wr = 0; m_dl_ok = 1;
      m_addr = '0; m_store = '0; m_il = '0; m_dl = '0;
    end else if (m_stage == 0) begin
      if ((dr || dw) && !(ir && m_cnt == int'(SMAX))) begin
        m_owner = 1; m_stage = 1; m_addr = da; m_store = ds; m_wr = dw;
        if (ir) m_cnt = m_cnt + 1;
      end else if (ir) begin
        m_owner = 2; m_stage = 1; m_addr = ia; m_wr = 0; m_cnt = 0;
      end
    end else if (m_stage == 1) begin
      if (rr) begin
        m_stage = 2;
        if (m_owner == 1) begin
          m_dl = rl; m_dl_ok = !m_wr;
        end else begin
          m_il = rl;
        end
      end
    end else begin
      m_stage = 0;
    end
  endtask

  task automatic model_check();
    chk("rnd_ren", W'(bus.ramREN), W'(m_stage == 1 && !m_wr));
    chk("rnd_wen", W'(bus.ramWEN), W'(m_stage == 1 && m_wr));
    chk("rnd_iwait", W'(bus.iwait), W'(!(m_stage == 2 && m_owner == 2)));
    chk("rnd_dwait", W'(bus.dwait), W'(!(m_stage == 2 && m_owner == 1)));
    chk("rnd_iload", bus.iload, m_il);
    if (m_dl_ok) chk("rnd_dload", bus.dload, m_dl);
    if (m_stage == 1) chk("rnd_ramaddr", bus.ramaddr, m_addr);
    if (m_stage == 1 && m_owner == 1) chk("rnd_ramstore", bus.ramstore, m_store);
  endtask

  initial begin
    int grants;
    logic [W-1:0] exp_a;
    bit r, ir, dr, dw, rr;
    logic [W-1:0] ia, da, ds, rl;

    //          rst ir dr dw ia      da      ds      rr rl            iw dw ren wen ca addr     cs store    cil il            cdl dl
    vt[0]  = '{1, 0, 0, 0, 32'h0,  32'h0,   32'h0,    0, 32'h0,        1, 1, 0, 0, 1, 32'h0,   1, 32'h0,    1, 32'h0,        1, 32'h0};
    vt[1]  = '{0, 1, 0, 0, 32'h40, 32'h0,   32'h0,    0, 32'h0,        1, 1, 1, 0, 1, 32'h40,  0, 32'h0,    1, 32'h0,        1, 32'h0};
    vt[2]  = '{0, 1, 0, 0, 32'h40, 32'h0,   32'h0,    0, 32'h0,        1, 1, 1, 0, 1, 32'h40,  0, 32'h0,    1, 32'h0,        1, 32'h0};
    vt[3]  = '{0, 1, 0, 0, 32'h40, 32'h0,   32'h0,    1, 32'hDEADBEEF, 0, 1, 0, 0, 0, 32'h0,   0, 32'h0,    1, 32'hDEADBEEF, 1, 32'h0};
    vt[4]  = '{0, 0, 0, 0, 32'h0,  32'h0,   32'h0,    0, 32'h0,        1, 1, 0, 0, 0, 32'h0,   0, 32'h0,    1, 32'hDEADBEEF, 1, 32'h0};
    vt[5]  = '{0, 1, 0, 1, 32'h44, 32'h100, 32'h1234, 0, 32'h0,        1, 1, 0, 1, 1, 32'h100, 1, 32'h1234, 1, 32'hDEADBEEF, 1, 32'h0};
    vt[6]  = '{0, 1, 0, 1, 32'h44, 32'h200, 32'h9999, 0, 32'h0,        1, 1, 0, 1, 1, 32'h100, 1, 32'h1234, 1, 32'hDEADBEEF, 1, 32'h0};
    vt[7]  = '{0, 1, 0, 1, 32'h44, 32'h200, 32'h9999, 1, 32'h0,        1, 0, 0, 0, 0, 32'h0,   0, 32'h0,    1, 32'hDEADBEEF, 0, 32'h0};
    vt[8]  = '{0, 1, 0, 0, 32'h44, 32'h0,   32'h0,    0, 32'h0,        1, 1, 0, 0, 0, 32'h0,   0, 32'h0,    1, 32'hDEADBEEF, 0, 32'h0};
    vt[9]  = '{0, 1, 0, 0, 32'h44, 32'h0,   32'h0,    0, 32'h0,        1, 1, 1, 0, 1, 32'h44,  0, 32'h0,    1, 32'hDEADBEEF, 0, 32'h0};
    vt[10] = '{0, 1, 0, 0, 32'h44, 32'h0,   32'h0,    1, 32'hCAFEF00D, 0, 1, 0, 0, 0, 32'h0,   0, 32'h0,    1, 32'hCAFEF00D, 0, 32'h0};
    vt[11] = '{0, 0, 0, 0, 32'h0,  32'h0,   32'h0,    0, 32'h0,        1, 1, 0, 0, 0, 32'h0,   0, 32'h0,    1, 32'hCAFEF00D, 0, 32'h0};
    vt[12] = '{0, 0, 1, 0, 32'h0,  32'h10,  32'h0,    0, 32'h0,        1, 1, 1, 0, 1, 32'h10,  0, 32'h0,    1, 32'hCAFEF00D, 0, 32'h0};
    vt[13] = '{0, 0, 0, 0, 32'h0,  32'h20,  32'h0,    0, 32'h0,        1, 1, 1, 0, 1, 32'h10,  0, 32'h0,    1, 32'hCAFEF00D, 0, 32'h0};
    vt[14] = '{0, 0, 0, 0, 32'h0,  32'h20,  32'h0,    1, 32'h55AA,     1, 0, 0, 0, 0, 32'h0,   0, 32'h0,    1, 32'hCAFEF00D, 1, 32'h55AA};
    vt[15] = '{0, 0, 0, 0, 32'h0,  32'h0,   32'h0,    0, 32'h0,        1, 1, 0, 0, 0, 32'h0,   0, 32'h0,    1, 32'hCAFEF00D, 1, 32'h55AA};
    vt[16] = '{0, 1, 0, 0, 32'h80, 32'h0,   32'h0,    0, 32'h0,        1, 1, 1, 0, 1, 32'h80,  0, 32'h0,    1, 32'hCAFEF00D, 1, 32'h55AA};
    vt[17] = '{1, 1, 0, 0, 32'h80, 32'h0,   32'h0,    0, 32'h0,        1, 1, 0, 0, 1, 32'h0,   1, 32'h0,    1, 32'h0,        1, 32'h0};
    vt[18] = '{0, 0, 0, 0, 32'h0,  32'h0,   32'h0,    1, 32'hFFFF,     1, 1, 0, 0, 1, 32'h0,   1, 32'h0,    1, 32'h0,        1, 32'h0};
    vt[19] = '{0, 0, 0, 0, 32'h0,  32'h0,   32'h0,    0, 32'h0,        1, 1, 0, 0, 1, 32'h0,   1, 32'h0,    1, 32'h0,        1, 32'h0};

    drv(1, 0, 0, 0, '0, '0, '0, 0, '0);
    @(negedge clk);

    // Directed table: single read, contention, mid-access change, reset mid-access.
    for (int i = 0; i < NV; i++) begin
      drv(vt[i].rst, vt[i].ir, vt[i].dr, vt[i].dw, vt[i].ia, vt[i].da, vt[i].ds, vt[i].rr, vt[i].rl);
      @(negedge clk);
      chk($sformatf("vec%0d_iwait", i), W'(bus.iwait), W'(vt[i].e_iw));
      chk($sformatf("vec%0d_dwait", i), W'(bus.dwait), W'(vt[i].e_dw));
      chk($sformatf("vec%0d_ramREN", i), W'(bus.ramREN), W'(vt[i].e_ren));
      chk($sformatf("vec%0d_ramWEN", i), W'(bus.ramWEN), W'(vt[i].e_wen));
      if (vt[i].c_addr)  chk($sformatf("vec%0d_ramaddr", i), bus.ramaddr, vt[i].e_addr);
      if (vt[i].c_store) chk($sformatf("vec%0d_ramstore", i), bus.ramstore, vt[i].e_store);
      if (vt[i].c_il)    chk($sformatf("vec%0d_iload", i), bus.iload, vt[i].e_il);
      if (vt[i].c_dl)    chk($sformatf("vec%0d_dload", i), bus.dload, vt[i].e_dl);
    end

    // Starvation: both requesters always asking, RAM always ready.
    drv(1, 0, 0, 0, '0, '0, '0, 0, '0);
    @(negedge clk);
    drv(0, 1, 1, 0, 32'h10, 32'hD0, '0, 1, 32'h77);
    grants = 0;
    for (int c = 0; c < 60 && grants < 11; c++) begin
      @(negedge clk);
      chk("starve_excl", W'(bus.ramREN & bus.ramWEN), '0);
      if (bus.ramREN || bus.ramWEN) begin
        exp_a = ((grants % (SMAX + 1)) == SMAX) ? 32'h10 : 32'hD0;
        chk($sformatf("starve_grant%0d", grants), bus.ramaddr, exp_a);
        grants++;
      end
    end
    chk("starve_grant_count", W'(grants), W'(11));

    // Back-to-back data reads with RAM always ready.
    drv(1, 0, 0, 0, '0, '0, '0, 0, '0);
    @(negedge clk);
    drv(0, 0, 1, 0, '0, 32'h30, '0, 1, 32'hABCD);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      chk($sformatf("b2b_dwait%0d", c), W'(bus.dwait), W'((c % 3) != 2));
      chk("b2b_excl", W'(bus.ramREN & bus.ramWEN), '0);
      if ((c % 3) == 2) chk("b2b_dload", bus.dload, 32'hABCD);
    end

    // Randomized traffic against the reference model.
    for (int c = 0; c < 4000; c++) begin
      if (c > 0) model_check();
      r  = (c == 0) || ($urandom_range(63) == 0);
      ir = ($urandom_range(99) < 55);
      dr = ($urandom_range(99) < 40);
      dw = ($urandom_range(99) < 25);
      ia = $urandom; da = $urandom; ds = $urandom;
      rr = ($urandom_range(99) < 40);
      rl = $urandom;
      drv(r, ir, dr, dw, ia, da, ds, rr, rl);
      model_step(r, ir, dr, dw, ia, da, ds, rr, rl);
      @(negedge clk);
    end
    model_check();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter WORD_W, default 32: data and address width.
REQ-002 SHALL have parameter STARVE_MAX, default 4: the maximum number of consecutive data grants allowed while an instruction request waits.
REQ-003 SHALL have port CLK  in  1  single clock; all state changes on the rising edge.
REQ-004 SHALL have port RST  in  1  reset, synchronous, active-high.
REQ-005 SHALL have ports iREN in 1 (instruction read request) and iaddr in WORD_W (instruction address).
REQ-006 SHALL have ports iwait out 1 (instruction stall) and iload out WORD_W (instruction read data).
REQ-007 SHALL have ports dREN in 1 (data read), dWEN in 1 (data write), daddr in WORD_W (address) and dstore in WORD_W (write data).
REQ-008 SHALL have ports dwait out 1 (data stall) and dload out WORD_W (data read data).
REQ-009 SHALL have ports ramREN out 1, ramWEN out 1, ramaddr out WORD_W and ramstore out WORD_W, which drive the single shared RAM port.
REQ-010 SHALL have ports ramload in WORD_W (RAM read data) and ramready in 1 (RAM access complete, one-cycle pulse).

Function
REQ-011 SHALL implement the FSM states IDLE, D_ACC, I_ACC, D_RESP and I_RESP.
REQ-012 In IDLE, an asserted dREN or dWEN SHALL transition the FSM to D_ACC, unless the starvation rule (REQ-014) applies; otherwise an asserted iREN SHALL transition it to I_ACC; otherwise the FSM SHALL stay in IDLE.
REQ-013 Data requests SHALL have priority over instruction requests in the same IDLE cycle.
REQ-014 Starvation counter scount (width ceil(log2(STARVE_MAX+1))):
- increments on each D grant made while iREN=1;
- clears on each I grant;
- holds otherwise;
- when scount==STARVE_MAX and iREN=1 in IDLE, the I grant SHALL be taken regardless of dREN/dWEN.
REQ-015 On any grant, SHALL latch the address, store data and the operation (write if dWEN=1, else read) into internal registers; dWEN=dREN=1 SHALL be treated as a write.
REQ-016 In D_ACC/I_ACC, SHALL drive ramaddr, ramstore, ramREN and ramWEN from the latched registers, held stable until ramready=1.
REQ-017 In D_ACC/I_ACC with ramready=1, SHALL capture ramload into the response register and transition to D_RESP/I_RESP respectively.
REQ-018 ramready SHALL be ignored in IDLE, D_RESP and I_RESP.
REQ-019 In D_RESP, SHALL drive dwait=0 and dload=captured data for exactly one cycle, then return to IDLE; I_RESP SHALL behave the same way on iwait/iload.
REQ-020 dwait SHALL be 1 in every state except D_RESP, and iwait SHALL be 1 in every state except I_RESP.
REQ-021 dload/iload SHALL hold the last captured value outside their RESP states; for a write, the captured value is don't-care.
REQ-022 ramREN and ramWEN SHALL be 0 outside the ACC states, and ramREN and ramWEN SHALL never be asserted together.
REQ-023 Latency: a request first seen in IDLE at edge N SHALL drive the RAM from cycle N+1; ramready at edge M SHALL give wait=0 during cycle M+1.
REQ-024 With ramready tied high, the minimum turnaround SHALL be 3 cycles per access (IDLE -> ACC -> RESP).
REQ-025 A request held high through its RESP cycle SHALL be re-arbitrated as a new request in the following IDLE cycle.
REQ-026 A requester dropping its request mid-access SHALL NOT abort the access: the access SHALL complete, the RESP cycle SHALL occur, and the response SHALL be ignored by the requester.
REQ-027 Input changes on iaddr, daddr or dstore during ACC SHALL NOT affect the RAM outputs.

Reset
REQ-028 With RST=1 at a rising edge, SHALL set state=IDLE, scount=0 and all latched and response registers to 0.
REQ-029 Reset outputs SHALL be: iwait=1, dwait=1, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, iload=0, dload=0.
REQ-030 Reset asserted mid-access SHALL abandon the access, with the RAM outputs deasserted from the next cycle; a ramready arriving after reset SHALL be ignored.

Verification
REQ-031 Single read: iREN=1, iaddr=0x40, ramready one cycle after ACC entry with ramload=0xDEADBEEF -> ramREN=1/ramaddr=0x40 for 2 cycles, then iwait=0 and iload=0xDEADBEEF for 1 cycle.
REQ-032 Contention: iREN=1 and dWEN=1 in the same cycle, daddr=0x100, dstore=0x1234 -> D access first (ramWEN=1, ramaddr=0x100, ramstore=0x1234), then I access, then iwait=0.
REQ-033 Starvation: iREN held high, dREN re-asserted every IDLE, STARVE_MAX=4 -> exactly 4 D grants, then an I grant, then scount=0.
REQ-034 Mid-access change: during D_ACC, change daddr from 0x10 to 0x20 and deassert dREN -> ramaddr stays 0x10, D_RESP still occurs, then IDLE.
REQ-035 Reset mid-access: RST=1 for one edge while in I_ACC, then ramready=1 -> ramREN=0, iwait=1, no I_RESP cycle, state IDLE.
REQ-036 Back-to-back: dREN held high for 3 accesses with ramready tied high -> dwait=0 on every third cycle, and ramREN/ramWEN never both high.
